// File: rtl/lib_pkt_pkg.sv
// Shared types and helpers for the lib_pkt_source packet generator:
// FSM state encoding, payload LFSR width/step function, packet field layout.
package lib_pkt_pkg;

  localparam int LFSR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Field layout of one packet at the default widths, MSB to LSB.
  typedef struct packed {
    logic [3:0]        id;
    logic [11:0]       seq;
    logic [LFSR_W-1:0] payload;
  } pkt_t;

  // Fibonacci LFSR, taps 16/14/13/11 (bits 15,13,12,10), shifting left.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/lib_lfsr16.sv
// 16-bit payload LFSR: advances one step on each cycle where ce && step,
// otherwise holds. Asynchronous active-high reset loads SEED.
module lib_lfsr16
  import lib_pkt_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              step,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (ce && step) lfsr_d = lfsr_next(lfsr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign o_lfsr = lfsr_q;

endmodule

// File: rtl/lib_pkt_source.sv
// Packet source feeding the write side of a val/en FIFO: bursts of
// {SRC_ID, seq, LFSR payload} with an optional idle gap between packets.
// Build option: define LIB_PKT_SOURCE_STALL_CNT_EN to enable o_stall_count.
module lib_pkt_source
  import lib_pkt_pkg::*;
#(
  parameter int                ID_W      = 4,
  parameter int                SEQ_W     = 12,
  parameter int                SRC_ID    = 0,
  parameter int                GAP_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  localparam int               WIDTH     = ID_W + SEQ_W + LFSR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             i_start,
  input  logic [15:0]      i_num_pkts,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_val,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_sent_count,
  output logic [15:0]      o_stall_count
);

  state_e             state_q, state_d;
  logic [15:0]        num_pkts_q, num_pkts_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [15:0]        sent_q, sent_d;
  logic [LFSR_W-1:0]  lfsr;

  logic start;
  logic xfer;
  logic last_pkt;

  assign start    = ce && (state_q == IDLE) && i_start;
  assign xfer     = ce && (state_q == SEND) && i_en;
  // Compared in 17 bits so the sent+1 test cannot wrap at 16'hFFFF.
  assign last_pkt = (num_pkts_q != '0) &&
                    (({1'b0, sent_q} + 17'd1) == {1'b0, num_pkts_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        IDLE: if (i_start) state_d = SEND;
        SEND: begin
          if (i_en) begin
            if (last_pkt)        state_d = DONE;
            else if (gap_q == '0) state_d = SEND;
            else                 state_d = GAP;
          end
        end
        GAP:  if (gap_cnt_q == GAP_W'(1)) state_d = SEND;
        DONE: if (!i_start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_data_val = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      SEND: begin
        o_data_val = 1'b1;
        o_busy     = 1'b1;
      end
      GAP:     o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    num_pkts_d = num_pkts_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    seq_d      = seq_q;
    sent_d     = sent_q;
    if (start) begin
      num_pkts_d = i_num_pkts;
      gap_d      = i_gap;
      sent_d     = '0;
    end
    if (xfer) begin
      seq_d = seq_q + SEQ_W'(1);
      if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
      if (!last_pkt)          gap_cnt_d = gap_q;
    end
    if (ce && (state_q == GAP)) gap_cnt_d = gap_cnt_q - GAP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_pkts_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      seq_q      <= '0;
      sent_q     <= '0;
    end else begin
      num_pkts_q <= num_pkts_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      seq_q      <= seq_d;
      sent_q     <= sent_d;
    end
  end

  lib_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .step   (xfer),
    .o_lfsr (lfsr)
  );

  assign o_data       = {ID_W'(SRC_ID), seq_q, lfsr};
  assign o_sent_count = sent_q;

`ifdef LIB_PKT_SOURCE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts cycles the packet is offered but the FIFO refuses it.
  always_comb begin
    stall_d = stall_q;
    if (start)
      stall_d = '0;
    else if (ce && (state_q == SEND) && !i_en && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_stall_count = stall_q;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_lib_pkt_source.sv
// Scoreboard bench for lib_pkt_source (SRC_ID=3): stimulus pushes expected
// packets from a behavioural model, a negedge monitor pops one per transfer.
module tb_lib_pkt_source;
  import lib_pkt_pkg::*;

  localparam int SRC = 3;
`ifdef LIB_PKT_SOURCE_STALL_CNT_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        i_start;
  logic [15:0] i_num_pkts;
  logic [7:0]  i_gap;
  logic        i_en;
  logic [31:0] o_data;
  logic        o_data_val;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_sent_count;
  logic [15:0] o_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb[$];
  int          m_seq;
  logic [15:0] m_lfsr;

  lib_pkt_source #(
    .ID_W      (4),
    .SEQ_W     (12),
    .SRC_ID    (SRC),
    .GAP_W     (8),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ce            (ce),
    .i_start       (i_start),
    .i_num_pkts    (i_num_pkts),
    .i_gap         (i_gap),
    .i_en          (i_en),
    .o_data        (o_data),
    .o_data_val    (o_data_val),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_sent_count  (o_sent_count),
    .o_stall_count (o_stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload rule: shift left, feedback is the parity of taps 15,13,12,10.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  task automatic model_reset();
    m_seq  = 0;
    m_lfsr = 16'hACE1;
    sb.delete();
  endtask

  task automatic push_pkts(input int n);
    pkt_t p;
    for (int k = 0; k < n; k++) begin
      p.id      = 4'(SRC);
      p.seq     = 12'(m_seq);
      p.payload = m_lfsr;
      sb.push_back(p);
      m_seq  = (m_seq + 1) % 4096;
      m_lfsr = ref_lfsr(m_lfsr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_start = 1'b0;
    ce      = 1'b1;
    i_en    = 1'b1;
    #2;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  // Issues a start; returns with the DUT in its first SEND cycle.
  task automatic start_burst(input int n_cfg, input int gap, input int n_push);
    push_pkts(n_push);
    i_num_pkts = 16'(n_cfg);
    i_gap      = 8'(gap);
    i_start    = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Monitor: one expected packet is consumed per accepted transfer.
  always @(negedge clk) begin
    if (!reset && ce && o_data_val && i_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected none", o_data);
      end else begin
        check("sb_data", {32'h0, o_data}, {32'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] pat;
    int cycles;
    logic busy_ok, done_seen;

    reset = 1'b1; ce = 1'b1; i_start = 1'b0; i_num_pkts = '0; i_gap = '0; i_en = 1'b1;
    model_reset();
    step(); step();
    check("rst_data",  o_data, 32'h3000ACE1);
    check("rst_val",   o_data_val, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_done",  o_done, 0);
    check("rst_sent",  o_sent_count, 0);
    check("rst_stall", o_stall_count, 0);
    reset = 1'b0;
    step();

    // Two back-to-back packets.
    start_burst(2, 0, 2);
    check("t1_pkt0", o_data, 32'h3000ACE1);
    check("t1_val0", o_data_val, 1);
    step();
    check("t1_pkt1", o_data, 32'h300159C3);
    step();
    check("t1_done", o_done, 1);
    check("t1_sent", o_sent_count, 2);
    check("t1_val_done", o_data_val, 0);
    step();
    check("t1_idle", o_done, 0);

    // Downstream refuses for five cycles.
    do_reset();
    i_en = 1'b0;
    start_burst(1, 0, 1);
    for (int c = 0; c < 5; c++) begin
      check("t2_hold", o_data, 32'h3000ACE1);
      check("t2_val", o_data_val, 1);
      step();
    end
    check("t2_stall", o_stall_count, STALL_EXP);
    i_en = 1'b1;
    step();
    check("t2_done", o_done, 1);
    step();

    // Gap of 3 between three packets.
    do_reset();
    pat = 9'b100010001;
    start_burst(3, 3, 3);
    for (int c = 0; c < 9; c++) begin
      check("t3_valid_pattern", o_data_val, pat[c]);
      step();
    end
    check("t3_done", o_done, 1);
    step();

    // ce toggling; seq/lfsr continue from the previous burst.
    start_burst(4, 0, 4);
    cycles = 0;
    while (!o_done && cycles < 50) begin
      ce = cycles[0];
      check("t4_val", o_data_val, 1);
      step();
      cycles++;
    end
    ce = 1'b1;
    check("t4_cycles", cycles, 8);
    check("t4_sent", o_sent_count, 4);
    step();

    // Asynchronous reset after one transfer.
    do_reset();
    start_burst(3, 0, 3);
    step();
    #2 reset = 1'b1;
    #1;
    check("t5_data", o_data, 32'h3000ACE1);
    check("t5_val",  o_data_val, 0);
    check("t5_busy", o_busy, 0);
    check("t5_done", o_done, 0);
    check("t5_sent", o_sent_count, 0);
    model_reset();
    step();
    reset = 1'b0;
    start_burst(1, 0, 1);
    check("t5_restart", o_data, 32'h3000ACE1);
    step();
    check("t5_done2", o_done, 1);
    step();

    // Unlimited mode across the sequence-number wrap.
    do_reset();
    start_burst(0, 0, 4100);
    busy_ok = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 4100; k++) begin
      if (!o_busy) busy_ok = 1'b0;
      if (o_done)  done_seen = 1'b1;
      step();
    end
    i_en = 1'b0;
    check("t6_busy", busy_ok, 1);
    check("t6_no_done", done_seen, 0);
    check("t6_sent", o_sent_count, 4100);
    check("t6_seq_wrap", o_data[27:16], 12'd4);
    check("t6_val", o_data_val, 1);
    check("t6_sb_empty", sb.size(), 0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lib_pkt_source.md
Name: lib_pkt_source

Overview:
- Packet transmitter that drives the write side of the team's val/en FIFOs.
- Generates a programmable number of packets. Each packet is {source ID, sequence number, LFSR payload}.
- An optional idle gap separates packets. Holds each packet stable until the downstream enable accepts it.
- Used as a traffic source in front of router input buffers in the network emulation fabric.

Parameters:
- ID_W, 4, width of source-ID field.
- SEQ_W, 12, width of sequence-number field (wraps modulo 2^SEQ_W).
- SRC_ID, 0, constant placed in ID field.
- GAP_W, 8, width of inter-packet gap count.
- LFSR_SEED, 16'hACE1, payload LFSR reset value (must be nonzero).
- Derived localparam WIDTH = ID_W+SEQ_W+16 (o_data width; 32 at defaults).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when low all state is frozen and no transfer occurs.
- i_start  in  1  level request to begin a burst.
- i_num_pkts  in  16  packets per burst, sampled on start; 0 = unlimited.
- i_gap  in  GAP_W  idle cycles between packets, sampled on start.
- i_en  in  1  downstream enable (FIFO o_en); transfer when ce && o_data_val && i_en.
- o_data  out  WIDTH  packet {ID, seq, payload} (MSB to LSB).
- o_data_val  out  1  packet valid.
- o_busy  out  1  burst in progress.
- o_done  out  1  burst complete.
- o_sent_count  out  16  packets accepted in current burst.
- o_stall_count  out  16  see Optional Feature.

Behaviour:
- Reset (async, any state, including mid-burst):
  - state=IDLE; o_data_val=0, o_busy=0, o_done=0; o_sent_count=0, o_stall_count=0.
  - seq=0, lfsr=LFSR_SEED, gap counter=0.
  - o_data={SRC_ID,0,LFSR_SEED}.
- o_data is always {SRC_ID, seq, lfsr}. All outputs are registered or state-decoded; there is no combinational path from i_en to any output.
- FSM states and transitions (evaluated only when ce=1):
  - IDLE: if i_start, latch i_num_pkts and i_gap, clear o_sent_count, go to SEND next cycle (first valid one cycle after start sampled).
  - SEND: o_data_val=1. On transfer: seq+=1 (wrap), lfsr steps, o_sent_count+=1. Then:
    - if num_pkts!=0 and sent_count+1==num_pkts, go to DONE;
    - else if gap==0, stay in SEND (back-to-back packets, one per cycle while i_en=1);
    - else go to GAP with counter=gap.
  - Without a transfer, SEND holds o_data stable.
  - GAP: o_data_val=0; counter decrements each ce cycle; at counter==1, go to SEND. Gap of N gives exactly N idle cycles.
  - DONE: o_done=1, o_data_val=0; go to IDLE when i_start=0.
- o_busy=1 in SEND and GAP.
- seq and lfsr persist across bursts; only reset reinitialises them.
- Deasserting i_start mid-burst has no effect; the burst completes.
- LFSR: fb=l[15]^l[13]^l[12]^l[10]; next={l[14:0],fb}.
- o_sent_count saturates at 16'hFFFF in unlimited mode; transmission continues.
- ce low during SEND: o_data_val stays 1, but no transfer is counted even if i_en=1.

Optional Feature:
- Macro: LIB_PKT_SOURCE_STALL_CNT_EN.
- Defined: o_stall_count increments (saturating) on each ce cycle with o_data_val=1 and i_en=0. It clears on burst start.
- Undefined: o_stall_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package lib_pkt_pkg:
  - state enum {IDLE, SEND, GAP, DONE};
  - LFSR width constant 16;
  - LFSR next-state function;
  - packet field struct typedef.
- Sub-module lib_lfsr16: 16-bit LFSR with seed parameter, ce and step inputs, async active-high reset.

Test Plan:
- Reset, SRC_ID=3, i_num_pkts=2, i_gap=0, i_en=1, pulse i_start -> o_data 32'h3000ACE1 then 32'h300159C3 on consecutive cycles; o_done=1 one cycle after second transfer; o_sent_count=2.
- i_en held 0 for 5 cycles during SEND -> o_data stable at 32'h3000ACE1, o_data_val=1 throughout; with macro, o_stall_count=5; without, 0.
- i_gap=3, i_num_pkts=3, i_en=1 -> valid pattern 1,0,0,0,1,0,0,0,1; seq 0,1,2.
- ce toggled 0/1 every cycle with i_en=1 -> transfers only on ce=1 cycles; 4 packets take 8 cycles.
- Assert reset mid-burst after 1 transfer -> all outputs return to reset values immediately (async); next burst restarts at seq 0, payload ACE1.
- i_num_pkts=0, i_gap=0, 4100 transfers -> seq wraps 12'hFFF to 0; o_busy stays 1; o_done never asserts.
